// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-skip adder: stage count and the
// effective carry-in used by the first skip block.
package csa_pkg;

  function automatic int num_blk(input int width, input int block);
    return width / block;
  endfunction

  // Subtraction is A + ~B + 1, so the carry-in is forced high.
  function automatic logic eff_cin(input logic sub, input logic cin);
    return sub ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: ripple adder plus a skip mux that bypasses the ripple
// chain when every bit of the block propagates.
module csa_skip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  // NOTE: combinational logic uses blocking '=' so each bit sees the carry
  // computed by the previous loop iteration within the same evaluation.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      p[i]   = a[i] ^ b[i];
      sum[i] = p[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    cmsb = c[BLOCK-1];
    cout = (&p) ? cin : c[BLOCK];
  end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: one skip block per register stage,
// with a single global advance enable driving valid/ready at both ends.
module pipelined_carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NUM_BLK = num_blk(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0 || NUM_BLK < 1) begin : g_bad_params
    $fatal(1, "pipelined_carry_skip_adder: WIDTH must be a nonzero multiple of BLOCK");
  end

  // Per-stage registered state, exported so stage k+1 can read stage k.
  logic             v_r [NUM_BLK];
  logic             c_r [NUM_BLK];
  logic [WIDTH-1:0] a_r [NUM_BLK];
  logic [WIDTH-1:0] b_r [NUM_BLK];
  logic [WIDTH-1:0] s_r [NUM_BLK];
  logic             cm_w [NUM_BLK];
  logic             co_w [NUM_BLK];
  logic             adv;
  logic             ovf_q;

  assign adv       = !v_r[NUM_BLK-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_r[NUM_BLK-1];
  assign out_sum   = s_r[NUM_BLK-1];
  assign out_cout  = c_r[NUM_BLK-1];
  assign out_ovf   = ovf_q;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
    logic             v_in, c_in;
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic [BLOCK-1:0] sum_blk;
    logic             co_blk, cm_blk;
    logic             v_q, c_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;

    // Operands are kept shifted so the block under evaluation is always
    // in the low BLOCK bits; B is already conditioned for subtraction.
    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign c_in = eff_cin(in_sub, in_cin);
      assign a_in = in_a;
      assign b_in = in_sub ? ~in_b : in_b;
      assign s_in = '0;
    end else begin : g_body
      assign v_in = v_r[k-1];
      assign c_in = c_r[k-1];
      assign a_in = a_r[k-1];
      assign b_in = b_r[k-1];
      assign s_in = s_r[k-1];
    end

    csa_skip_block #(.BLOCK(BLOCK)) u_blk (
      .a    (a_in[BLOCK-1:0]),
      .b    (b_in[BLOCK-1:0]),
      .cin  (c_in),
      .sum  (sum_blk),
      .cout (co_blk),
      .cmsb (cm_blk)
    );

    always_comb begin
      s_nxt = s_in;
      s_nxt[k*BLOCK +: BLOCK] = sum_blk;
    end

    // NOTE: the datapath registers are reset too because out_sum must read
    // zero after reset; sequential state always uses non-blocking '<='.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= co_blk;
        a_q <= a_in >> BLOCK;
        b_q <= b_in >> BLOCK;
        s_q <= s_nxt;
      end
    end

    assign v_r[k]  = v_q;
    assign c_r[k]  = c_q;
    assign a_r[k]  = a_q;
    assign b_r[k]  = b_q;
    assign s_r[k]  = s_q;
    assign cm_w[k] = cm_blk;
    assign co_w[k] = co_blk;
  end

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= cm_w[NUM_BLK-1] ^ co_w[NUM_BLK-1];
    end
  end

endmodule
